// File: rtl/bounded_updown_counter_pkg.sv
// Shared types and helpers for the bounded up/down counter.
// The clamp helper works on a fixed wide vector; callers zero-extend and truncate.
package bounded_counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } counter_mode_e;

    localparam int CLAMP_W = 32;

    function automatic logic [CLAMP_W-1:0] clamp_value(
        input logic [CLAMP_W-1:0] value,
        input logic [CLAMP_W-1:0] lo,
        input logic [CLAMP_W-1:0] hi
    );
        logic [CLAMP_W-1:0] result;
        if (value < lo) begin
            result = lo;
        end else if (value > hi) begin
            result = hi;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/bounded_updown_counter_if.sv
// Control, configuration and status bundle of the bounded up/down counter.
// master drives requests and reads status; slave is the counter itself.
interface bounded_updown_counter_if #(
    parameter int N      = 8,
    parameter int STEP_W = 4
);
    logic              cfgWrite;
    logic [N-1:0]      cfgMin;
    logic [N-1:0]      cfgMax;
    logic              cfgMode;
    logic              syncClear;
    logic              load;
    logic [N-1:0]      loadValue;
    logic              enable;
    logic              upCount;
    logic [STEP_W-1:0] step;
    logic [N-1:0]      counterValue;
    logic              maxTick;
    logic              minTick;
    logic              boundTick;
    logic              cfgError;

    modport master (
        output cfgWrite, cfgMin, cfgMax, cfgMode,
        output syncClear, load, loadValue,
        output enable, upCount, step,
        input  counterValue, maxTick, minTick, boundTick, cfgError
    );

    modport slave (
        input  cfgWrite, cfgMin, cfgMax, cfgMode,
        input  syncClear, load, loadValue,
        input  enable, upCount, step,
        output counterValue, maxTick, minTick, boundTick, cfgError
    );

endinterface

// File: rtl/bounded_updown_counter_step_calc.sv
// Combinational next-count and bound-event logic for one enabled count step.
// All arithmetic is N+1 bits wide so sums and differences never overflow.
module bounded_step_calc
    import bounded_counter_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic [N-1:0]      value,
    input  logic [N-1:0]      cur_min,
    input  logic [N-1:0]      cur_max,
    input  counter_mode_e     mode,
    input  logic              up,
    input  logic [STEP_W-1:0] step,
    output logic [N-1:0]      next_value,
    output logic              bound_event
);

    localparam logic [N:0] ONE = (N+1)'(1);

    logic [N:0] value_ext;
    logic [N:0] min_ext;
    logic [N:0] max_ext;
    logic [N:0] step_ext;
    logic [N:0] range;
    logic [N:0] sum;
    logic [N:0] floor_val;
    logic       step_exceeds_range;

    assign value_ext          = {1'b0, value};
    assign min_ext            = {1'b0, cur_min};
    assign max_ext            = {1'b0, cur_max};
    assign step_ext           = {{(N+1-STEP_W){1'b0}}, step};
    assign range              = max_ext - min_ext;
    assign sum                = value_ext + step_ext;
    // value - step >= min is evaluated as value >= min + step to stay unsigned
    assign floor_val          = min_ext + step_ext;
    assign step_exceeds_range = step_ext > range;

    always_comb begin
        next_value  = value;
        bound_event = 1'b0;
        if (step_ext == '0) begin
            next_value  = value;
            bound_event = 1'b0;
        end else if (up) begin
            if (sum <= max_ext) begin
                next_value = N'(sum);
            end else begin
                bound_event = 1'b1;
                if (mode == MODE_SAT) begin
                    next_value = cur_max;
                end else if (step_exceeds_range) begin
                    next_value = cur_min;
                end else begin
                    next_value = N'(min_ext + (sum - max_ext - ONE));
                end
            end
        end else begin
            if (value_ext >= floor_val) begin
                next_value = N'(value_ext - step_ext);
            end else begin
                bound_event = 1'b1;
                if (mode == MODE_SAT) begin
                    next_value = cur_min;
                end else if (step_exceeds_range) begin
                    next_value = cur_max;
                end else begin
                    next_value = N'(max_ext - (floor_val - value_ext - ONE));
                end
            end
        end
    end

endmodule

// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter: range/mode registers, request priority mux and config validation.
// Priority per cycle is cfgWrite > syncClear > load > enable; only the winner acts.
module bounded_updown_counter
    import bounded_counter_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    bounded_updown_counter_if.slave   bus
);

    logic [N-1:0]  count_q;
    logic [N-1:0]  count_d;
    logic [N-1:0]  cur_min_q;
    logic [N-1:0]  cur_min_d;
    logic [N-1:0]  cur_max_q;
    logic [N-1:0]  cur_max_d;
    counter_mode_e cur_mode_q;
    counter_mode_e cur_mode_d;
    logic          bound_tick_q;
    logic          bound_tick_d;
    logic          cfg_error_q;
    logic          cfg_error_d;

    logic [N-1:0]  step_next;
    logic          step_bound;
    logic [N-1:0]  load_clamped;
    logic          cfg_valid;

    bounded_step_calc #(
        .N      (N),
        .STEP_W (STEP_W)
    ) u_step_calc (
        .value       (count_q),
        .cur_min     (cur_min_q),
        .cur_max     (cur_max_q),
        .mode        (cur_mode_q),
        .up          (bus.upCount),
        .step        (bus.step),
        .next_value  (step_next),
        .bound_event (step_bound)
    );

    assign load_clamped = N'(clamp_value(CLAMP_W'(bus.loadValue),
                                         CLAMP_W'(cur_min_q),
                                         CLAMP_W'(cur_max_q)));
    assign cfg_valid    = bus.cfgMin <= bus.cfgMax;

    always_comb begin
        count_d      = count_q;
        cur_min_d    = cur_min_q;
        cur_max_d    = cur_max_q;
        cur_mode_d   = cur_mode_q;
        bound_tick_d = 1'b0;
        cfg_error_d  = 1'b0;
        if (bus.cfgWrite) begin
            // a rejected write still consumes the cycle
            if (cfg_valid) begin
                cur_min_d  = bus.cfgMin;
                cur_max_d  = bus.cfgMax;
                cur_mode_d = counter_mode_e'(bus.cfgMode);
                count_d    = bus.cfgMin;
            end else begin
                cfg_error_d = 1'b1;
            end
        end else if (bus.syncClear) begin
            count_d = cur_min_q;
        end else if (bus.load) begin
            count_d = load_clamped;
        end else if (bus.enable) begin
            count_d      = step_next;
            bound_tick_d = step_bound;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q      <= '0;
            cur_min_q    <= '0;
            cur_max_q    <= '1;
            cur_mode_q   <= MODE_WRAP;
            bound_tick_q <= 1'b0;
            cfg_error_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            cur_min_q    <= cur_min_d;
            cur_max_q    <= cur_max_d;
            cur_mode_q   <= cur_mode_d;
            bound_tick_q <= bound_tick_d;
            cfg_error_q  <= cfg_error_d;
        end
    end

    assign bus.counterValue = count_q;
    assign bus.maxTick      = count_q == cur_max_q;
    assign bus.minTick      = count_q == cur_min_q;
    assign bus.boundTick    = bound_tick_q;
    assign bus.cfgError     = cfg_error_q;

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Directed bench for bounded_updown_counter at N=4, STEP_W=3: vector table plus
// hand-written sequences for the full-range count and asynchronous reset.
module tb_bounded_updown_counter;

    localparam int N      = 4;
    localparam int STEP_W = 3;

    typedef struct {
        logic              cw;
        logic [N-1:0]      cmin;
        logic [N-1:0]      cmax;
        logic              cmode;
        logic              clr;
        logic              ld;
        logic [N-1:0]      ldv;
        logic              en;
        logic              up;
        logic [STEP_W-1:0] step;
        logic [N-1:0]      ev;
        logic              emax;
        logic              emin;
        logic              eb;
        logic              ee;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    vec_t vecs[$];

    bounded_updown_counter_if #(.N(N), .STEP_W(STEP_W)) bus ();

    bounded_updown_counter #(.N(N), .STEP_W(STEP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic cw, input int cmin, input int cmax, input logic cmode,
        input logic clr, input logic ld, input int ldv,
        input logic en, input logic up, input int step,
        input int ev, input logic emax, input logic emin, input logic eb, input logic ee
    );
        vec_t v;
        v.cw = cw; v.cmin = N'(cmin); v.cmax = N'(cmax); v.cmode = cmode;
        v.clr = clr; v.ld = ld; v.ldv = N'(ldv);
        v.en = en; v.up = up; v.step = STEP_W'(step);
        v.ev = N'(ev); v.emax = emax; v.emin = emin; v.eb = eb; v.ee = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic check_all(input string tag, input int ev, input logic emax,
                             input logic emin, input logic eb, input logic ee);
        check({tag, " value"},     8'(bus.counterValue), 8'(ev));
        check({tag, " maxTick"},   8'(bus.maxTick),      8'(emax));
        check({tag, " minTick"},   8'(bus.minTick),      8'(emin));
        check({tag, " boundTick"}, 8'(bus.boundTick),    8'(eb));
        check({tag, " cfgError"},  8'(bus.cfgError),     8'(ee));
    endtask

    task automatic drive(input vec_t v);
        bus.cfgWrite  = v.cw;
        bus.cfgMin    = v.cmin;
        bus.cfgMax    = v.cmax;
        bus.cfgMode   = v.cmode;
        bus.syncClear = v.clr;
        bus.load      = v.ld;
        bus.loadValue = v.ldv;
        bus.enable    = v.en;
        bus.upCount   = v.up;
        bus.step      = v.step;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        idle();

        //        cw cmin cmax mode clr ld ldv en up st  ev mx mn b  e
        vecs.push_back(mk(1, 3, 12, 1, 0, 0, 0,  0, 0, 0,  3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 1, 10, 0, 0, 0, 10, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 1, 3, 12, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 1, 3, 12, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 1, 0, 12, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3, 12, 0, 0, 0, 0,  0, 0, 0,  3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 1, 11, 0, 0, 0, 11, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 1, 3,  4, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 0, 3, 11, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 0, 3,  8, 0, 0, 0, 0));
        vecs.push_back(mk(1, 9, 5,  1, 0, 0, 0,  1, 1, 3,  8, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 1, 3, 11, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 1, 3,  4, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,  0, 1, 1, 7,  1, 1, 3,  3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 1, 14, 0, 0, 0, 12, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1,  0, 0, 0,  3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 1, 7, 10, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 1, 7,  7, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  0, 1, 5,  7, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 5,  0, 0, 0, 0,  0, 0, 0,  5, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 1, 2,  5, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 0, 1,  5, 1, 1, 1, 0));
        vecs.push_back(mk(1, 2, 13, 0, 1, 0, 0,  0, 0, 0,  2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 0, 7,  7, 0, 0, 1, 0));
        vecs.push_back(mk(1, 2, 6,  0, 0, 0, 0,  0, 0, 0,  2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 1, 5,  2, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 0, 5,  6, 1, 0, 1, 0));
        vecs.push_back(mk(1, 2, 13, 1, 0, 0, 0,  0, 0, 0,  2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 0, 1,  2, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 1, 7,  9, 0, 0, 0, 0));
        vecs.push_back(mk(1, 12, 3, 0, 0, 1, 5,  0, 0, 0,  9, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  9, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 1, 4, 13, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0,  1, 1, 1, 13, 1, 0, 1, 0));

        repeat (2) @(posedge clk);
        #1 check_all("reset_hold", 0, 0, 1, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1 check_all("after_reset", 0, 0, 1, 0, 0);

        // full-range count with the reset configuration 0..15 wrap
        bus.enable  = 1'b1;
        bus.upCount = 1'b1;
        bus.step    = 3'd1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            #1 check_all($sformatf("full_up[%0d]", i), i, (i == 15), 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1 check_all("full_wrap", 0, 0, 1, 1, 0);
        bus.enable = 1'b0;
        @(posedge clk);
        #1 check_all("full_hold", 0, 0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1 check_all($sformatf("vec[%0d]", i), int'(vecs[i].ev), vecs[i].emax,
                         vecs[i].emin, vecs[i].eb, vecs[i].ee);
        end

        // asynchronous reset in the middle of a count
        drive(mk(1, 4, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 check_all("pre_rst_cfg", 4, 0, 1, 0, 0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 check_all("pre_rst_cnt1", 5, 0, 0, 0, 0);
        @(posedge clk);
        #1 check_all("pre_rst_cnt2", 6, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1 check_all("async_rst", 0, 0, 1, 0, 0);
        @(posedge clk);
        #1 check_all("rst_held", 0, 0, 1, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 check_all("resume1", 1, 0, 0, 0, 0);
        @(posedge clk);
        #1 check_all("resume2", 2, 0, 0, 0, 0);
        drive(mk(0, 0, 0, 0, 0, 1, 15, 1, 1, 1, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 check_all("rst_max15", 15, 1, 0, 0, 0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 check_all("rst_wrap0", 0, 0, 1, 1, 0);
        idle();
        @(posedge clk);
        #1 check_all("final_idle", 0, 0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
